// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the main-memory responder: command encoding,
// default geometry and the pending-response packet.
package mem_responder_pkg;

    localparam int XLEN        = 32;
    localparam int MEM_DWORDS  = 8192;
    localparam int MEM_LATENCY = 10;
    localparam int TAG_W       = 4;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_command_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
        logic [CNT_W-1:0] cnt;
    } MEM_RESP_PKT;

    // Tags run 1..num_tags; 0 is reserved for "no tag".
    function automatic logic [TAG_W-1:0] tag_advance(input logic [TAG_W-1:0] tag,
                                                     input int               num_tags);
        return (int'(tag) >= num_tags) ? TAG_W'(1) : tag + TAG_W'(1);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// proc2mem / mem2proc bus between the cache mux (master) and main memory (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    bus_command_e      proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface

// File: rtl/mem_responder_pending_fifo.sv
// In-order queue of accepted loads; every entry counts down each cycle and the
// head is released on the cycle its countdown reaches its final step.
module mem_responder_pending_fifo
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  MEM_RESP_PKT push_pkt,
    output logic        pop,
    output MEM_RESP_PKT head_pkt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    MEM_RESP_PKT   entry      [DEPTH];
    MEM_RESP_PKT   entry_next [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // A pushed entry carries LATENCY-1, so cnt==1 marks the cycle whose edge loads the output register.
    assign head_pkt = entry[head];
    assign pop      = (count != '0) && (head_pkt.cnt == CNT_W'(1));

    always_comb begin
        entry_next = entry;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry[i].cnt != '0) entry_next[i].cnt = entry[i].cnt - CNT_W'(1);
        end
        if (push) entry_next[tail] = push_pkt;
    end

    always_ff @(posedge clock) begin
        entry <= entry_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Tagged main-memory responder: same-cycle tag on acceptance, load data and tag
// returned a fixed LATENCY cycles after the acceptance edge.
module mem_responder #(
    parameter int MEM_DWORDS      = mem_responder_pkg::MEM_DWORDS,
    parameter int LATENCY         = mem_responder_pkg::MEM_LATENCY,
    parameter int MAX_OUTSTANDING = 4,
    parameter int NUM_TAGS        = 15
) (
    input  logic                           clock,
    input  logic                           reset,
    mem_responder_if.slave                 bus,
    input  logic                           init_we,
    input  logic [mem_responder_pkg::XLEN-1:0] init_addr,
    input  logic [63:0]                    init_data
);
    import mem_responder_pkg::*;

    localparam int   IW     = $clog2(MEM_DWORDS);
    localparam int   OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic BYPASS = (LATENCY == 1);

    if (NUM_TAGS < 1 || NUM_TAGS > 15) begin : g_chk_tags
        $error("mem_responder: NUM_TAGS must be within 1..15");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_TAGS) begin : g_chk_outstanding
        $error("mem_responder: MAX_OUTSTANDING must be within 1..NUM_TAGS");
    end
    if (LATENCY < 1 || LATENCY >= (1 << CNT_W)) begin : g_chk_latency
        $error("mem_responder: LATENCY out of range");
    end

    function automatic logic addr_ok(input logic [XLEN-1:3] a);
        return (a[XLEN-1:IW+3] == '0) && ({{(32-IW){1'b0}}, a[IW+2:3]} < 32'(MEM_DWORDS));
    endfunction

    logic [63:0]      mem [MEM_DWORDS];
    logic [IW-1:0]    cmd_idx;
    logic [IW-1:0]    init_idx;
    logic             load_ok;
    logic             store_ok;
    logic             load_return;
    logic             fifo_pop;
    logic [TAG_W-1:0] next_tag;
    logic [OW-1:0]    outstanding;
    MEM_RESP_PKT      load_pkt_p0;
    MEM_RESP_PKT      head_pkt;
    logic [TAG_W-1:0] ret_tag_d;
    logic [63:0]      ret_data_d;
    logic [TAG_W-1:0] ret_tag_p1;
    logic [63:0]      ret_data_p1;
    logic             unused_bits;

    assign unused_bits = ^{bus.proc2mem_addr[2:0], init_addr[2:0], head_pkt.cnt};

    assign cmd_idx  = bus.proc2mem_addr[IW+2:3];
    assign init_idx = init_addr[IW+2:3];

    // Stage p0: acceptance against the registered outstanding count (no same-cycle bypass).
    always_comb begin
        load_ok  = !reset && addr_ok(bus.proc2mem_addr[XLEN-1:3])
                   && (bus.proc2mem_command == BUS_LOAD) && (outstanding < OW'(MAX_OUTSTANDING));
        store_ok = !reset && addr_ok(bus.proc2mem_addr[XLEN-1:3])
                   && (bus.proc2mem_command == BUS_STORE);
        bus.mem2proc_response = (load_ok || store_ok) ? next_tag : '0;
        load_pkt_p0 = '{tag: next_tag, data: mem[cmd_idx], cnt: CNT_W'(LATENCY - 1)};
    end

    always_ff @(posedge clock) begin
        if (init_we && !reset && addr_ok(init_addr[XLEN-1:3]) && !(store_ok && init_idx == cmd_idx))
            mem[init_idx] <= init_data;
        if (store_ok)
            mem[cmd_idx] <= bus.proc2mem_data;
    end

    mem_responder_pending_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_pending (
        .clock    (clock),
        .reset    (reset),
        .push     (load_ok && !BYPASS),
        .push_pkt (load_pkt_p0),
        .pop      (fifo_pop),
        .head_pkt (head_pkt)
    );

    assign load_return = BYPASS ? load_ok : fifo_pop;

    always_comb begin
        ret_tag_d  = '0;
        ret_data_d = '0;
        if (BYPASS) begin
            if (load_ok) begin
                ret_tag_d  = load_pkt_p0.tag;
                ret_data_d = load_pkt_p0.data;
            end
        end else if (fifo_pop) begin
            ret_tag_d  = head_pkt.tag;
            ret_data_d = head_pkt.data;
        end
    end

    // Stage p1: registered return bus, tag allocator and in-flight count.
    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag    <= TAG_W'(1);
            outstanding <= '0;
            ret_tag_p1  <= '0;
            ret_data_p1 <= '0;
        end else begin
            if (load_ok || store_ok) next_tag <= tag_advance(next_tag, NUM_TAGS);
            if (load_ok && !load_return)      outstanding <= outstanding + OW'(1);
            else if (!load_ok && load_return) outstanding <= outstanding - OW'(1);
            ret_tag_p1  <= ret_tag_d;
            ret_data_p1 <= ret_data_d;
        end
    end

    assign bus.mem2proc_tag  = ret_tag_p1;
    assign bus.mem2proc_data = ret_data_p1;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: acceptance tags checked the cycle they are
// driven, load returns checked against a queue of expected {tag, data, cycle}.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LAT = 10;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        init_we;
    logic [31:0] init_addr;
    logic [63:0] init_data;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    bit          mon_en      = 1'b0;
    exp_t        sb [$];
    exp_t        ret;
    logic [63:0] model [int];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_responder_if bus ();

    mem_responder #(
        .MEM_DWORDS      (8192),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (4),
        .NUM_TAGS        (15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    function automatic int didx(input logic [31:0] a);
        return int'(a[15:3]);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", name, obs, expv);
        end
    endtask

    task automatic step_idle(input int n);
        repeat (n) begin
            @(negedge clock); #1;
            bus.proc2mem_command = BUS_NONE;
            init_we = 1'b0;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [63:0] d);
        @(negedge clock); #1;
        bus.proc2mem_command = BUS_NONE;
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        model[didx(a)] = d;
    endtask

    task automatic issue(input bus_command_e cmd, input logic [31:0] a, input logic [63:0] d,
                         input logic [3:0] exp_resp, input string name);
        @(negedge clock); #1;
        init_we = 1'b0;
        bus.proc2mem_command = cmd;
        bus.proc2mem_addr    = a;
        bus.proc2mem_data    = d;
        #1;
        chk(name, 64'(bus.mem2proc_response), 64'(exp_resp));
        if (exp_resp != 4'd0) begin
            if (cmd == BUS_STORE) model[didx(a)] = d;
            else sb.push_back('{tag: exp_resp, data: model[didx(a)], due: cyc + LAT});
        end
    endtask

    // Return-bus monitor: a return exactly on its due cycle, zeros on every other cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                ret = sb.pop_front();
                chk("return_tag", 64'(bus.mem2proc_tag), 64'(ret.tag));
                chk("return_data", bus.mem2proc_data, ret.data);
            end else begin
                chk("idle_tag", 64'(bus.mem2proc_tag), 64'd0);
                chk("idle_data", bus.mem2proc_data, 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;

        // Reset state and rejection while reset is high
        repeat (2) @(negedge clock);
        #1 bus.proc2mem_command = BUS_LOAD;
        bus.proc2mem_addr = 32'h1000;
        #1 chk("reset_response", 64'(bus.mem2proc_response), 64'd0);
        @(negedge clock); #1;
        chk("reset_tag", 64'(bus.mem2proc_tag), 64'd0);
        chk("reset_data", bus.mem2proc_data, 64'd0);
        bus.proc2mem_command = BUS_NONE;
        reset  = 1'b0;
        mon_en = 1'b1;

        preload(32'h1000, 64'hDEAD_BEEF_0000_0001);
        preload(32'h0000, 64'h0123_4567_89AB_CDEF);
        preload(32'h3000, 64'h3000_0000_0000_0A0A);
        preload(32'h3008, 64'h3008_0000_0000_0B0B);
        preload(32'h3010, 64'h3010_0000_0000_0C0C);
        preload(32'h6000, 64'h6000_0000_0000_6666);

        // T1: single load, fixed latency
        issue(BUS_LOAD, 32'h1000, '0, 4'd1, "t1_load");
        step_idle(12);

        // T2: store then misaligned load of the same dword
        issue(BUS_STORE, 32'h2008, 64'h55, 4'd2, "t2_store");
        issue(BUS_LOAD,  32'h200C, '0,     4'd3, "t2_load");
        step_idle(12);

        // T3: fifth back-to-back load is rejected, retry later succeeds
        issue(BUS_LOAD, 32'h1000, '0, 4'd4, "t3_load1");
        issue(BUS_LOAD, 32'h3000, '0, 4'd5, "t3_load2");
        issue(BUS_LOAD, 32'h3008, '0, 4'd6, "t3_load3");
        issue(BUS_LOAD, 32'h3010, '0, 4'd7, "t3_load4");
        issue(BUS_LOAD, 32'h2008, '0, 4'd0, "t3_full_reject");
        step_idle(12);
        issue(BUS_LOAD, 32'h3000, '0, 4'd8, "t3_retry");
        step_idle(12);

        // T6: full with head return -> reject; one below full with head return -> accept
        issue(BUS_LOAD, 32'h1000, '0, 4'd9,  "t6_load1");
        issue(BUS_LOAD, 32'h3000, '0, 4'd10, "t6_load2");
        issue(BUS_LOAD, 32'h3008, '0, 4'd11, "t6_load3");
        issue(BUS_LOAD, 32'h3010, '0, 4'd12, "t6_load4");
        step_idle(5);
        issue(BUS_LOAD, 32'h1000, '0, 4'd0,  "t6_no_bypass");
        issue(BUS_LOAD, 32'h0000, '0, 4'd13, "t6_accept_on_return");
        issue(BUS_LOAD, 32'h3000, '0, 4'd14, "t6_steady_a");
        issue(BUS_LOAD, 32'h3008, '0, 4'd15, "t6_steady_b");
        issue(BUS_LOAD, 32'h3010, '0, 4'd1,  "t6_fill_wrap");
        issue(BUS_LOAD, 32'h1000, '0, 4'd0,  "t6_full_again");
        step_idle(14);

        // T4: tag wrap across 16 accepted stores, out-of-range commands leave no trace
        for (int i = 0; i < 16; i++) begin
            if (i == 8) issue(BUS_LOAD, 32'h0001_0000, '0, 4'd0, "t4_oor_load");
            issue(BUS_STORE, 32'h4000 + 32'(i * 8), 64'h100 + 64'(i),
                  4'(((i + 1) % 15) + 1), "t4_wrap_store");
        end
        issue(BUS_STORE, 32'h0001_0000, 64'hBAD, 4'd0, "t4_oor_store");
        issue(BUS_LOAD,  32'h8000_1000, '0,      4'd0, "t4_oor_high");
        issue(BUS_LOAD,  32'h4028,      '0,      4'd3, "t4_store_readback");
        issue(BUS_LOAD,  32'h0000,      '0,      4'd4, "t4_oor_no_write");
        step_idle(12);

        // Store and preload to the same dword in one cycle: store wins
        @(negedge clock); #1;
        bus.proc2mem_command = BUS_STORE;
        bus.proc2mem_addr    = 32'h5000;
        bus.proc2mem_data    = 64'hAAAA_0000_0000_0001;
        init_we   = 1'b1;
        init_addr = 32'h5000;
        init_data = 64'hBBBB_0000_0000_0002;
        #1 chk("store_vs_init_response", 64'(bus.mem2proc_response), 64'd5);
        model[didx(32'h5000)] = 64'hAAAA_0000_0000_0001;
        issue(BUS_LOAD, 32'h5000, '0, 4'd6, "store_wins_load");
        step_idle(12);

        // T5: reset with three loads in flight drops them; preload during reset ignored
        issue(BUS_LOAD, 32'h1000, '0, 4'd7, "t5_load1");
        issue(BUS_LOAD, 32'h3000, '0, 4'd8, "t5_load2");
        issue(BUS_LOAD, 32'h3008, '0, 4'd9, "t5_load3");
        @(negedge clock); #1;
        reset = 1'b1;
        sb.delete();
        bus.proc2mem_command = BUS_LOAD;
        bus.proc2mem_addr    = 32'h1000;
        init_we   = 1'b1;
        init_addr = 32'h6000;
        init_data = 64'hBAD0_BAD0_BAD0_BAD0;
        #1 chk("t5_reject_in_reset", 64'(bus.mem2proc_response), 64'd0);
        @(negedge clock);
        @(negedge clock); #1;
        reset = 1'b0;
        bus.proc2mem_command = BUS_NONE;
        init_we = 1'b0;
        step_idle(14);
        issue(BUS_LOAD, 32'h1000, '0, 4'd1, "t5_first_tag_after_reset");
        issue(BUS_LOAD, 32'h6000, '0, 4'd2, "t5_init_ignored_in_reset");
        step_idle(12);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
